// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory request/ack channel plus the decode-side pair/redirect channel.
interface instruction_fetch_unit_if #(
  parameter int PC_bitSize = 11
);
  logic                  imem_req;
  logic [PC_bitSize-1:0] imem_addr;
  logic                  imem_ack;
  logic [63:0]           imem_rdata;
  logic                  id_ready;
  logic                  branch_result;
  logic [PC_bitSize-1:0] branch_address;
  logic                  id_valid;
  logic [31:0]           instruction_even;
  logic [31:0]           instruction_odd;
  logic [PC_bitSize-1:0] pc_out;
  logic [PC_bitSize-1:0] pcpluseight_out;

  modport master (
    output imem_req, imem_addr,
    input  imem_ack, imem_rdata,
    input  id_ready, branch_result, branch_address,
    output id_valid, instruction_even, instruction_odd, pc_out, pcpluseight_out
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ack, imem_rdata,
    output id_ready, branch_result, branch_address,
    input  id_valid, instruction_even, instruction_odd, pc_out, pcpluseight_out
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetches 64-bit instruction pairs into a 2-entry queue for decode; pair visible one cycle after ack.
// Backpressure: no new request is issued while the queue would be full; redirects flush and drop stale acks.
module instruction_fetch_unit #(
  parameter int PC_bitSize = 11
) (
  input  logic                     clk,
  input  logic                     reset,
  instruction_fetch_unit_if.master bus
);
  typedef enum logic {FETCH, DISCARD} state_t;

  typedef struct packed {
    logic [63:0]           pair;
    logic [PC_bitSize-1:0] pc;
  } entry_t;

  localparam logic [PC_bitSize-1:0] PC_STEP    = PC_bitSize'(8);
  localparam logic [PC_bitSize-1:0] ALIGN_MASK = ~PC_bitSize'(7);

  state_t                state_q, state_d;
  logic                  req_q, req_d;
  logic [PC_bitSize-1:0] fetch_pc_q, fetch_pc_d;
  logic [PC_bitSize-1:0] target_q, target_d;
  entry_t                mem_q [2];
  entry_t                mem_d [2];
  logic                  rd_ptr_q, rd_ptr_d;
  logic                  wr_ptr_q, wr_ptr_d;
  logic [1:0]            count_q, count_d;

  logic                  ack;
  logic                  pop;
  logic                  push;
  logic                  id_valid;
  logic [PC_bitSize-1:0] branch_target;
  entry_t                head;

  // An ack only counts against a live request, so late acks after reset are ignored.
  assign ack           = req_q & bus.imem_ack;
  assign id_valid      = (count_q != 2'd0);
  assign pop           = id_valid & bus.id_ready;
  assign branch_target = bus.branch_address & ALIGN_MASK;
  assign head          = mem_q[rd_ptr_q];

  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    fetch_pc_d = fetch_pc_q;
    target_d   = target_q;
    mem_d      = mem_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    push       = 1'b0;
    case (state_q)
      FETCH: begin
        if (bus.branch_result) begin
          rd_ptr_d = 1'b0;
          wr_ptr_d = 1'b0;
          count_d  = 2'd0;
          if (req_q && !bus.imem_ack) begin
            state_d  = DISCARD;
            target_d = branch_target;
          end else begin
            fetch_pc_d = branch_target;
            req_d      = 1'b1;
          end
        end else begin
          push = ack;
          if (push) begin
            mem_d[wr_ptr_q].pair = bus.imem_rdata;
            mem_d[wr_ptr_q].pc   = fetch_pc_q;
            wr_ptr_d             = ~wr_ptr_q;
            fetch_pc_d           = fetch_pc_q + PC_STEP;
          end
          if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
          end
          count_d = count_q + {1'b0, push} - {1'b0, pop};
          // Issue the next fetch only if its data is guaranteed a free slot.
          if (!req_q || ack) begin
            req_d = (count_d <= 2'd1);
          end
        end
      end
      DISCARD: begin
        if (bus.branch_result) begin
          target_d = branch_target;
        end
        if (ack) begin
          state_d    = FETCH;
          fetch_pc_d = bus.branch_result ? branch_target : target_q;
          req_d      = 1'b1;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= FETCH;
      req_q      <= 1'b0;
      fetch_pc_q <= '0;
      target_q   <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      fetch_pc_q <= fetch_pc_d;
      target_q   <= target_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign bus.imem_req         = req_q;
  assign bus.imem_addr        = fetch_pc_q;
  assign bus.id_valid         = id_valid;
  assign bus.instruction_even = id_valid ? head.pair[63:32] : 32'd0;
  assign bus.instruction_odd  = id_valid ? head.pair[31:0]  : 32'd0;
  assign bus.pc_out           = id_valid ? head.pc : '0;
  assign bus.pcpluseight_out  = id_valid ? head.pc + PC_STEP : '0;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
module tb_instruction_fetch_unit;
  localparam int W = 11;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  instruction_fetch_unit_if #(.PC_bitSize(W)) bus ();
  instruction_fetch_unit #(.PC_bitSize(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [63:0]  pair;
    logic [W-1:0] pc;
  } ent_t;

  ent_t         mq[$];
  logic         m_req;
  logic [W-1:0] m_pc;
  logic         m_disc;
  logic [W-1:0] m_tgt;

  task automatic drive(input logic ack, input logic [63:0] rdata, input logic rdy,
                       input logic br, input logic [W-1:0] baddr);
    bus.imem_ack       = ack;
    bus.imem_rdata     = rdata;
    bus.id_ready       = rdy;
    bus.branch_result  = br;
    bus.branch_address = baddr;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 1'b0, '0);
    reset = 1'b1;
    drive(1'b0, 64'd0, 1'b0, 1'b0, '0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, '0);
    drive(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, '0);
    n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL rst_req got=%0h want=0", bus.imem_req); end
    n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0h want=0", bus.id_valid); end
    n_tests++; if (bus.pc_out !== 11'h000) begin n_fail++; $display("FAIL rst_pc got=%0h want=0", bus.pc_out); end
    n_tests++; if (bus.pcpluseight_out !== 11'h000) begin n_fail++; $display("FAIL rst_pc8 got=%0h want=0", bus.pcpluseight_out); end
    n_tests++; if (bus.instruction_even !== 32'd0) begin n_fail++; $display("FAIL rst_even got=%0h want=0", bus.instruction_even); end
    n_tests++; if (bus.instruction_odd !== 32'd0) begin n_fail++; $display("FAIL rst_odd got=%0h want=0", bus.instruction_odd); end
    reset = 1'b1;
    drive(1'b0, 64'd0, 1'b0, 1'b0, '0);
    n_tests++; if (bus.imem_req !== 1'b1) begin n_fail++; $display("FAIL rel_req got=%0h want=1", bus.imem_req); end
    n_tests++; if (bus.imem_addr !== 11'h000) begin n_fail++; $display("FAIL rel_addr got=%0h want=0", bus.imem_addr); end
  endtask

  task automatic test_basic_fetch();
    do_reset();
    drive(1'b0, 64'd0, 1'b1, 1'b0, '0);
    n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pre_valid got=%0h want=0", bus.id_valid); end
    drive(1'b1, 64'hAAAA0001_BBBB0002, 1'b1, 1'b0, '0);
    n_tests++; if (bus.id_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid got=%0h want=1", bus.id_valid); end
    n_tests++; if (bus.instruction_even !== 32'hAAAA0001) begin n_fail++; $display("FAIL basic_even got=%0h want=aaaa0001", bus.instruction_even); end
    n_tests++; if (bus.instruction_odd !== 32'hBBBB0002) begin n_fail++; $display("FAIL basic_odd got=%0h want=bbbb0002", bus.instruction_odd); end
    n_tests++; if (bus.pc_out !== 11'h000) begin n_fail++; $display("FAIL basic_pc got=%0h want=0", bus.pc_out); end
    n_tests++; if (bus.pcpluseight_out !== 11'h008) begin n_fail++; $display("FAIL basic_pc8 got=%0h want=8", bus.pcpluseight_out); end
    n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 11'h008) begin n_fail++; $display("FAIL basic_next req=%0h addr=%0h want 1/8", bus.imem_req, bus.imem_addr); end
    drive(1'b0, 64'd0, 1'b1, 1'b0, '0);
    n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL basic_popped got=%0h want=0", bus.id_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    drive(1'b1, 64'h11111111_22222222, 1'b0, 1'b0, '0);
    n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 11'h008) begin n_fail++; $display("FAIL bp_second req=%0h addr=%0h want 1/8", bus.imem_req, bus.imem_addr); end
    drive(1'b1, 64'h33333333_44444444, 1'b0, 1'b0, '0);
    n_tests++; if (bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL bp_full_req got=%0h want=0", bus.imem_req); end
    n_tests++; if (bus.id_valid !== 1'b1 || bus.pc_out !== 11'h000) begin n_fail++; $display("FAIL bp_head valid=%0h pc=%0h want 1/0", bus.id_valid, bus.pc_out); end
    drive(1'b1, 64'h55555555_66666666, 1'b0, 1'b0, '0);
    n_tests++; if (bus.imem_req !== 1'b0 || bus.pc_out !== 11'h000) begin n_fail++; $display("FAIL bp_stray_ack req=%0h pc=%0h want 0/0", bus.imem_req, bus.pc_out); end
    n_tests++; if (bus.instruction_even !== 32'h11111111) begin n_fail++; $display("FAIL bp_head_even got=%0h want=11111111", bus.instruction_even); end
    drive(1'b0, 64'd0, 1'b1, 1'b0, '0);
    n_tests++; if (bus.pc_out !== 11'h008 || bus.instruction_even !== 32'h33333333) begin n_fail++; $display("FAIL bp_pop1 pc=%0h even=%0h want 8/33333333", bus.pc_out, bus.instruction_even); end
    n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 11'h010) begin n_fail++; $display("FAIL bp_resume req=%0h addr=%0h want 1/10", bus.imem_req, bus.imem_addr); end
    drive(1'b0, 64'd0, 1'b1, 1'b0, '0);
    n_tests++; if (bus.id_valid !== 1'b0 || bus.imem_addr !== 11'h010) begin n_fail++; $display("FAIL bp_pop2 valid=%0h addr=%0h want 0/10", bus.id_valid, bus.imem_addr); end
  endtask

  task automatic test_branch_discard();
    drive(1'b0, 64'd0, 1'b1, 1'b1, 11'h123);
    n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 11'h010) begin n_fail++; $display("FAIL disc_hold req=%0h addr=%0h want 1/10", bus.imem_req, bus.imem_addr); end
    drive(1'b0, 64'd0, 1'b1, 1'b0, '0);
    n_tests++; if (bus.imem_addr !== 11'h010 || bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL disc_wait addr=%0h valid=%0h want 10/0", bus.imem_addr, bus.id_valid); end
    drive(1'b1, 64'hDEADDEAD_DEADDEAD, 1'b1, 1'b0, '0);
    n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL disc_drop valid=%0h want=0", bus.id_valid); end
    n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 11'h120) begin n_fail++; $display("FAIL disc_target req=%0h addr=%0h want 1/120", bus.imem_req, bus.imem_addr); end
    drive(1'b1, 64'h12012012_0120120C, 1'b1, 1'b0, '0);
    n_tests++; if (bus.id_valid !== 1'b1 || bus.pc_out !== 11'h120 || bus.instruction_even !== 32'h12012012) begin n_fail++; $display("FAIL disc_first valid=%0h pc=%0h even=%0h want 1/120/12012012", bus.id_valid, bus.pc_out, bus.instruction_even); end
  endtask

  task automatic test_branch_ack_pop();
    drive(1'b1, 64'hBAD0BAD0_BAD0BAD0, 1'b1, 1'b1, 11'h344);
    n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL bap_valid got=%0h want=0", bus.id_valid); end
    n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 11'h340) begin n_fail++; $display("FAIL bap_addr req=%0h addr=%0h want 1/340", bus.imem_req, bus.imem_addr); end
    drive(1'b0, 64'd0, 1'b1, 1'b0, '0);
    n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL bap_empty got=%0h want=0", bus.id_valid); end
  endtask

  task automatic test_wrap();
    drive(1'b0, 64'd0, 1'b1, 1'b1, 11'h7FF);
    drive(1'b1, 64'd0, 1'b1, 1'b0, '0);
    n_tests++; if (bus.imem_addr !== 11'h7F8) begin n_fail++; $display("FAIL wrap_req addr=%0h want=7f8", bus.imem_addr); end
    drive(1'b1, 64'h7F87F87F_87F87F87, 1'b0, 1'b0, '0);
    n_tests++; if (bus.pc_out !== 11'h7F8 || bus.pcpluseight_out !== 11'h000) begin n_fail++; $display("FAIL wrap_pc pc=%0h pc8=%0h want 7f8/0", bus.pc_out, bus.pcpluseight_out); end
    n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 11'h000) begin n_fail++; $display("FAIL wrap_next req=%0h addr=%0h want 1/0", bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 1'b0, '0);
    n_tests++; if (bus.id_valid !== 1'b0 || bus.imem_req !== 1'b0) begin n_fail++; $display("FAIL midrst valid=%0h req=%0h want 0/0", bus.id_valid, bus.imem_req); end
    n_tests++; if (bus.pc_out !== 11'h000 || bus.instruction_even !== 32'd0) begin n_fail++; $display("FAIL midrst_out pc=%0h even=%0h want 0/0", bus.pc_out, bus.instruction_even); end
    reset = 1'b1;
    drive(1'b1, 64'hAAAAAAAA_AAAAAAAA, 1'b1, 1'b0, '0);
    n_tests++; if (bus.id_valid !== 1'b0) begin n_fail++; $display("FAIL late_ack valid=%0h want=0", bus.id_valid); end
    n_tests++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 11'h000) begin n_fail++; $display("FAIL midrst_fetch req=%0h addr=%0h want 1/0", bus.imem_req, bus.imem_addr); end
    drive(1'b1, 64'h0C0C0C0C_D0D0D0D0, 1'b0, 1'b0, '0);
    n_tests++; if (bus.pc_out !== 11'h000 || bus.instruction_odd !== 32'hD0D0D0D0) begin n_fail++; $display("FAIL midrst_data pc=%0h odd=%0h want 0/d0d0d0d0", bus.pc_out, bus.instruction_odd); end
  endtask

  task automatic test_random();
    logic         ack, rdy, br, rst, acc, popm;
    logic [63:0]  rdata;
    logic [W-1:0] baddr, aligned;
    ent_t         e;
    do_reset();
    mq.delete();
    m_req = 1'b1; m_pc = '0; m_disc = 1'b0; m_tgt = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      n_tests++; if (bus.imem_req !== m_req) begin n_fail++; $display("FAIL rnd_req cyc=%0d got=%0h want=%0h", cyc, bus.imem_req, m_req); end
      if (m_req) begin
        n_tests++; if (bus.imem_addr !== m_pc) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got=%0h want=%0h", cyc, bus.imem_addr, m_pc); end
      end
      n_tests++; if (bus.id_valid !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid cyc=%0d got=%0h want=%0h", cyc, bus.id_valid, mq.size() != 0); end
      if (mq.size() != 0) begin
        n_tests++; if ({bus.instruction_even, bus.instruction_odd} !== mq[0].pair) begin n_fail++; $display("FAIL rnd_pair cyc=%0d got=%0h want=%0h", cyc, {bus.instruction_even, bus.instruction_odd}, mq[0].pair); end
        n_tests++; if (bus.pc_out !== mq[0].pc) begin n_fail++; $display("FAIL rnd_pc cyc=%0d got=%0h want=%0h", cyc, bus.pc_out, mq[0].pc); end
        n_tests++; if (bus.pcpluseight_out !== W'(mq[0].pc + W'(8))) begin n_fail++; $display("FAIL rnd_pc8 cyc=%0d got=%0h want=%0h", cyc, bus.pcpluseight_out, W'(mq[0].pc + W'(8))); end
      end
      ack   = 1'($urandom_range(0, 1));
      rdata = {$urandom, $urandom};
      rdy   = ($urandom_range(0, 9) < 6);
      br    = ($urandom_range(0, 19) == 0);
      baddr = W'($urandom);
      rst   = ($urandom_range(0, 199) != 0);
      reset              = rst;
      bus.imem_ack       = ack;
      bus.imem_rdata     = rdata;
      bus.id_ready       = rdy;
      bus.branch_result  = br;
      bus.branch_address = baddr;
      aligned = baddr & ~W'(7);
      acc  = m_req && ack;
      popm = (mq.size() != 0) && rdy;
      if (!rst) begin
        mq.delete(); m_req = 1'b0; m_pc = '0; m_disc = 1'b0;
      end else if (m_disc) begin
        if (br) m_tgt = aligned;
        if (acc) begin m_disc = 1'b0; m_pc = m_tgt; m_req = 1'b1; end
      end else if (br) begin
        mq.delete();
        if (m_req && !acc) begin m_disc = 1'b1; m_tgt = aligned; end
        else begin m_pc = aligned; m_req = 1'b1; end
      end else begin
        if (popm) void'(mq.pop_front());
        if (acc) begin
          e.pair = rdata; e.pc = m_pc;
          mq.push_back(e);
          m_pc = m_pc + W'(8);
        end
        if (!m_req || acc) m_req = (mq.size() <= 1);
      end
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  initial begin
    bus.imem_ack = 1'b0; bus.imem_rdata = '0; bus.id_ready = 1'b0;
    bus.branch_result = 1'b0; bus.branch_address = '0;
    @(negedge clk);
    test_reset();
    test_basic_fetch();
    test_backpressure();
    test_branch_discard();
    test_branch_ack_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
